// File: rtl/eaglesong_input_packer.sv
// Packs a 1..32 byte message little-endian into a 256-bit absorb block and emits
// one or two absorb beats. Optional stats counters: EAGLESONG_PACKER_STATS_EN.
module eaglesong_input_packer #(
  parameter int unsigned RATE_BYTES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_input_val,
  output logic [6:0]   out_length_bytes,
  output logic [7:0]   out_absorb_round_num,
  output logic         out_final,
  output logic         err_overflow
`ifdef EAGLESONG_PACKER_STATS_EN
  ,
  output logic [31:0]  msg_count,
  output logic [15:0]  drop_count
`endif
);

  if (RATE_BYTES != 32) begin : g_rate_check
    $error("eaglesong_input_packer: only RATE_BYTES=32 is supported");
  end

  typedef enum logic [1:0] {FILL, DROP, EMIT0, EMIT1} state_t;

  state_t       state_q, state_d;
  logic [255:0] buf_q;
  logic [5:0]   cnt_q;
  logic         accept, out_hs, full;
  logic         clear, store, ovf_d;

  assign accept = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign full   = (cnt_q == 6'd32);

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    store   = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (full) begin
            // 33rd byte: a final byte here completes the drop immediately
            if (in_last) begin
              ovf_d = 1'b1;
              clear = 1'b1;
            end else begin
              state_d = DROP;
            end
          end else begin
            store = 1'b1;
            if (in_last) state_d = EMIT0;
          end
        end
      end
      DROP: begin
        if (accept && in_last) begin
          ovf_d   = 1'b1;
          clear   = 1'b1;
          state_d = FILL;
        end
      end
      EMIT0: begin
        if (out_hs) begin
          if (full) begin
            state_d = EMIT1;
          end else begin
            clear   = 1'b1;
            state_d = FILL;
          end
        end
      end
      EMIT1: begin
        if (out_hs) begin
          clear   = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      buf_q        <= '0;
      cnt_q        <= '0;
      in_ready     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready     <= (state_d == FILL) || (state_d == DROP);
      err_overflow <= ovf_d;
      if (clear) begin
        buf_q <= '0;
        cnt_q <= '0;
      end else if (store) begin
        buf_q[{cnt_q[4:0], 3'b000} +: 8] <= in_data;
        cnt_q                            <= cnt_q + 6'd1;
      end
    end
  end

  assign out_valid            = (state_q == EMIT0) || (state_q == EMIT1);
  assign out_input_val        = buf_q;
  assign out_length_bytes     = {1'b0, cnt_q};
  assign out_absorb_round_num = {7'd0, state_q == EMIT1};
  assign out_final            = (state_q == EMIT1) || ((state_q == EMIT0) && !full);

`ifdef EAGLESONG_PACKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_count  <= '0;
      drop_count <= '0;
    end else begin
      if (out_hs && out_final) msg_count <= msg_count + 32'd1;
      if (err_overflow && (drop_count != '1)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eaglesong_input_packer.sv
// Self-checking bench for eaglesong_input_packer: vector table plus scoreboard of
// expected absorb beats, with directed latency, stall, overflow and reset sequences.
module tb_eaglesong_input_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last;
  logic [7:0]   in_data;
  logic         out_valid, out_ready, out_final, err_overflow;
  logic [255:0] out_input_val;
  logic [6:0]   out_length_bytes;
  logic [7:0]   out_absorb_round_num;
`ifdef EAGLESONG_PACKER_STATS_EN
  logic [31:0]  msg_count;
  logic [15:0]  drop_count;
`endif

  eaglesong_input_packer #(.RATE_BYTES(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_input_val(out_input_val),
    .out_length_bytes(out_length_bytes), .out_absorb_round_num(out_absorb_round_num),
    .out_final(out_final), .err_overflow(err_overflow)
`ifdef EAGLESONG_PACKER_STATS_EN
    , .msg_count(msg_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] val;
    logic [6:0]   len;
    logic [7:0]   round;
    logic         fin;
  } beat_t;

  typedef struct {
    int          len;
    logic [7:0]  base;
    int          stall;
    int          exp_beats;
    int          exp_ovf;
  } vec_t;

  beat_t sb[$];
  int    checks = 0;
  int    passed = 0;
  int    beats_seen = 0;
  int    ovf_cycles = 0;
  int    exp_msgs = 0;
  int    exp_drops = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_msg(input int len, input logic [7:0] base);
    beat_t        b;
    logic [255:0] v = '0;
    for (int i = 0; i < len; i++) v[i*8 +: 8] = base + 8'(i);
    b.val = v; b.len = 7'(len); b.round = 8'd0; b.fin = (len != 32);
    sb.push_back(b);
    if (len == 32) begin
      b.round = 8'd1; b.fin = 1'b1;
      sb.push_back(b);
    end
    exp_msgs++;
  endtask

  // Monitor: scoreboard compare on handshake, stability while stalled
  beat_t prev;
  logic  prev_hold = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 256'(out_valid), 256'(1'b1));
        check("hold_val", out_input_val, prev.val);
        check("hold_len", 256'(out_length_bytes), 256'(prev.len));
        check("hold_round", 256'(out_absorb_round_num), 256'(prev.round));
        check("hold_final", 256'(out_final), 256'(prev.fin));
      end
      if (out_valid) check("in_ready_low_in_emit", 256'(in_ready), 256'(1'b0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got beat len=%0d round=%0d, expected no beat",
                   out_length_bytes, out_absorb_round_num);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_val", out_input_val, e.val);
          check("beat_len", 256'(out_length_bytes), 256'(e.len));
          check("beat_round", 256'(out_absorb_round_num), 256'(e.round));
          check("beat_final", 256'(out_final), 256'(e.fin));
        end
        beats_seen++;
      end
      prev_hold  = out_valid && !out_ready;
      prev.val   = out_input_val;
      prev.len   = out_length_bytes;
      prev.round = out_absorb_round_num;
      prev.fin   = out_final;
      if (err_overflow) ovf_cycles++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    if (!in_ready) begin
      checks++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    wait_ready();
    in_valid = 1'b1; in_data = d; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) send_byte(base + 8'(i), i == len - 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin step(); n++; end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", sb.size());
      sb.delete();
    end
    repeat (2) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 256'(in_ready), '0);
    check({tag, "_out_valid"}, 256'(out_valid), '0);
    check({tag, "_val"}, out_input_val, '0);
    check({tag, "_len"}, 256'(out_length_bytes), '0);
    check({tag, "_round"}, 256'(out_absorb_round_num), '0);
    check({tag, "_final"}, 256'(out_final), '0);
    check({tag, "_err"}, 256'(err_overflow), '0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{len:1,  base:8'h10, stall:0, exp_beats:1, exp_ovf:0};
    vecs[1] = '{len:5,  base:8'h20, stall:2, exp_beats:1, exp_ovf:0};
    vecs[2] = '{len:31, base:8'h40, stall:0, exp_beats:1, exp_ovf:0};
    vecs[3] = '{len:32, base:8'h80, stall:3, exp_beats:2, exp_ovf:0};
    vecs[4] = '{len:35, base:8'h00, stall:0, exp_beats:0, exp_ovf:1};
    vecs[5] = '{len:2,  base:8'h01, stall:0, exp_beats:1, exp_ovf:0};
    vecs[6] = '{len:33, base:8'h50, stall:0, exp_beats:0, exp_ovf:1};
    vecs[7] = '{len:40, base:8'h90, stall:0, exp_beats:0, exp_ovf:1};
    vecs[8] = '{len:17, base:8'hC0, stall:1, exp_beats:1, exp_ovf:0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) step();
    check_all_zero("reset");
    rst = 1'b0;
    check("ready_before_edge", 256'(in_ready), '0);
    step();
    check("ready_after_edge", 256'(in_ready), 256'(1'b1));

    // 3-byte message, one-cycle latency
    push_msg(3, 8'h61);
    send_msg(3, 8'h61);
    check("abc_valid", 256'(out_valid), 256'(1'b1));
    check("abc_val", out_input_val, 256'h636261);
    check("abc_len", 256'(out_length_bytes), 256'd3);
    drain();

    // 32-byte message: two back-to-back beats
    push_msg(32, 8'h00);
    send_msg(32, 8'h00);
    check("m32_b0_round", 256'(out_absorb_round_num), '0);
    check("m32_b0_final", 256'(out_final), '0);
    check("m32_b0_top", 256'(out_input_val[255:248]), 256'h1F);
    step();
    check("m32_b1_valid", 256'(out_valid), 256'(1'b1));
    check("m32_b1_round", 256'(out_absorb_round_num), 256'd1);
    check("m32_b1_final", 256'(out_final), 256'(1'b1));
    step();
    check("m32_done_valid", 256'(out_valid), '0);
    check("m32_done_ready", 256'(in_ready), 256'(1'b1));
    drain();

    // single byte held by out_ready=0 for 5 cycles
    out_ready = 1'b0;
    push_msg(1, 8'hAA);
    send_msg(1, 8'hAA);
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 256'(out_valid), 256'(1'b1));
      check("stall_val", out_input_val, 256'hAA);
      check("stall_in_ready", 256'(in_ready), '0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("stall_after_valid", 256'(out_valid), '0);
    check("stall_after_ready", 256'(in_ready), 256'(1'b1));
    drain();

    for (int v = 0; v < 9; v++) begin
      int b0, o0;
      b0 = beats_seen;
      o0 = ovf_cycles;
      if (vecs[v].len <= 32) push_msg(vecs[v].len, vecs[v].base);
      else exp_drops++;
      if (vecs[v].stall > 0) out_ready = 1'b0;
      send_msg(vecs[v].len, vecs[v].base);
      repeat (vecs[v].stall) step();
      out_ready = 1'b1;
      drain();
      check("vec_beats", 256'(beats_seen - b0), 256'(vecs[v].exp_beats));
      check("vec_ovf_cycles", 256'(ovf_cycles - o0), 256'(vecs[v].exp_ovf));
    end

    // asynchronous reset in the middle of a message
    for (int i = 0; i < 10; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    step();
    rst = 1'b0;
`ifdef EAGLESONG_PACKER_STATS_EN
    exp_msgs = 0;
    exp_drops = 0;
`endif
    push_msg(4, 8'h30);
    send_msg(4, 8'h30);
    drain();
    push_msg(5, 8'h70);
    send_msg(5, 8'h70);
    drain();
    push_msg(32, 8'hA0);
    send_msg(32, 8'hA0);
    drain();
    exp_drops++;
    send_msg(40, 8'h11);
    drain();

`ifdef EAGLESONG_PACKER_STATS_EN
    check("msg_count", 256'(msg_count), 256'(exp_msgs));
    check("drop_count", 256'(drop_count), 256'(exp_drops));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected completion within 1ms");
    $fatal(1);
  end

endmodule
